aes_spi_slave: RTL and testbench

SPI-style serial front end for the AES encryption path. Receives a 128-bit plaintext block and a 32·NK-bit cipher key bit-serially on SIMO, runs them through the team's existing AES encryption core, and streams the 128-bit ciphertext back on SOMI. Sits between the off-chip SPI master and the AES cipher datapath.

---
 rtl/aes_spi_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_aes_spi_slave.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_slave.sv
// Bit-serial AES encryption front end: shifts in a block and a key, encrypts, and shifts the ciphertext out.
// Define AES_SPI_MSB_FIRST_EN to shift both directions MSB first; the default is LSB first.

module aes_core #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic [127:0]      block,
    input  logic [32*NK-1:0]  key,
    output logic [127:0]      result
);
    localparam int KB = 32 * NK;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box built from the GF(2^8) inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = gmul(a, a);
        for (int i = 1; i < 8; i++) begin
            r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [KB-1:0] k);
        logic [31:0]  w [4*(NR+1)];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4*(NR+1); i++) begin
            if (i < NK) begin
                w[i] = k[32*(NK-1-i) +: 32];
            end else begin
                tmp = w[i-1];
                if (i % NK == 0) begin
                    tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                    rc  = xtime(rc);
                end else if (NK > 6 && i % NK == 4) begin
                    tmp = sub_word(tmp);
                end
                w[i] = w[i-NK] ^ tmp;
            end
        end
        // Byte j of the state is row j%4, column j/4; byte 0 is the block's top byte.
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int r = 1; r <= NR; r++) begin
            for (int j = 0; j < 16; j++) t[j] = sbox(s[j]);
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
            if (r < NR) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) s[4*c+q] = s[4*c+q] ^ w[4*r+c][31-8*q -: 8];
        end
        res = '0;
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
        return res;
    endfunction

    always_comb result = encrypt(block, key);
endmodule

module aes_spi_slave #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SIMO,
    input  logic       CSS,
    input  logic       mode,
    output logic       SOMI,
    output logic [1:0] state_dbg
);
    localparam int KEY_BITS = 32 * NK;
    localparam int CW       = $clog2(KEY_BITS);

    typedef enum logic [1:0] {
        LOAD_MSG = 2'd0,
        LOAD_KEY = 2'd1,
        COMPUTE  = 2'd2,
        READY    = 2'd3
    } state_t;

    state_t              state_q, state_n;
    logic [CW-1:0]       cnt;
    logic [6:0]          oidx;
    logic [127:0]        msg;
    logic [KEY_BITS-1:0] key;
    logic [127:0]        ct;
    logic [127:0]        core_out;
    logic                somi_q;
    logic                mode_q;

    logic          restart, ld_msg, ld_key, ct_ld, tx_rdy, tx_zero, tx_first;
    logic [6:0]    msg_idx, tx_idx, tx_bit;
    logic [CW-1:0] key_idx;

    aes_core #(.NK(NK), .NR(NR)) u_core (
        .block  (msg),
        .key    (key),
        .result (core_out)
    );

    // Protocol: with CSS low every rising edge samples mode; mode=0 shifts SIMO in, mode=1 shifts ct out.
    // A sampled 0->1 on mode restarts the output index, a sampled 1->0 starts a new load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= LOAD_MSG;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        if (state_q == COMPUTE) begin
            state_n = READY;
        end else if (!CSS && !mode) begin
            if (mode_q) begin
                state_n = LOAD_MSG;
            end else begin
                unique case (state_q)
                    LOAD_MSG: if (cnt == CW'(127))          state_n = LOAD_KEY;
                    LOAD_KEY: if (cnt == CW'(KEY_BITS - 1)) state_n = COMPUTE;
                    default:                                state_n = state_q;
                endcase
            end
        end
    end

    always_comb begin
        restart  = !CSS && !mode && mode_q && (state_q != COMPUTE);
        ld_msg   = !CSS && !mode && !mode_q && (state_q == LOAD_MSG);
        ld_key   = !CSS && !mode && !mode_q && (state_q == LOAD_KEY);
        ct_ld    = (state_q == COMPUTE);
        tx_rdy   = !CSS && mode && (state_q == READY);
        tx_zero  = !CSS && mode && (state_q != READY);
        tx_first = !CSS && mode && !mode_q;
    end

    assign tx_idx = mode_q ? oidx : 7'd0;

`ifdef AES_SPI_MSB_FIRST_EN
    assign msg_idx = ~cnt[6:0];
    assign key_idx = CW'(KEY_BITS - 1) - cnt;
    assign tx_bit  = ~tx_idx;
`else
    assign msg_idx = cnt[6:0];
    assign key_idx = cnt;
    assign tx_bit  = tx_idx;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            oidx   <= '0;
            msg    <= '0;
            key    <= '0;
            ct     <= '0;
            somi_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            if (!CSS) mode_q <= mode;
            if (restart) begin
                cnt    <= '0;
                somi_q <= 1'b0;
            end
            if (ld_msg) begin
                msg[msg_idx] <= SIMO;
                cnt          <= (cnt == CW'(127)) ? '0 : cnt + 1'b1;
            end
            if (ld_key) begin
                key[key_idx] <= SIMO;
                cnt          <= (cnt == CW'(KEY_BITS - 1)) ? '0 : cnt + 1'b1;
            end
            if (ct_ld) ct <= core_out;
            if (tx_rdy) begin
                somi_q <= ct[tx_bit];
                oidx   <= tx_idx + 7'd1;
            end else begin
                if (tx_zero)  somi_q <= 1'b0;
                if (tx_first) oidx   <= 7'd0;
            end
        end
    end

    // The registered bit is gated so a deselected slave never drives data.
    assign SOMI      = somi_q & ~CSS;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_aes_spi_slave.sv
// Directed testbench for aes_spi_slave (NK=4, NR=10, LSB-first default build).
// Uses the FIPS-197 and Appendix C.1 AES-128 vectors.

module tb_aes_spi_slave;
    localparam int NK = 4;
    localparam int NR = 10;
    localparam int KB = 32 * NK;

    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       SIMO = 1'b0;
    logic       CSS = 1'b1;
    logic       mode = 1'b0;
    logic       SOMI;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_spi_slave #(.NK(NK), .NR(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .SIMO      (SIMO),
        .CSS       (CSS),
        .mode      (mode),
        .SOMI      (SOMI),
        .state_dbg (state_dbg)
    );

    task automatic send_bit(input logic b);
        @(negedge clk);
        CSS  = 1'b0;
        mode = 1'b0;
        SIMO = b;
    endtask

    // A 1->0 mode edge only restarts the load, so it takes one edge of its own.
    task automatic start_load();
        if (mode) begin
            @(negedge clk);
            CSS  = 1'b0;
            mode = 1'b0;
            SIMO = 1'b1;
        end
    endtask

    task automatic load_block(input logic [127:0] m, input logic [KB-1:0] k, input int pause_at);
        start_load();
        for (int i = 0; i < 128; i++) send_bit(m[i]);
        for (int i = 0; i < KB; i++) begin
            if (i == pause_at) begin
                for (int p = 0; p < 5; p++) begin
                    @(negedge clk);
                    CSS  = 1'b1;
                    SIMO = ~SIMO;
                    #1;
                    total++;
                    if (SOMI !== 1'b0 || state_dbg !== 2'd1) begin
                        bad++;
                        $display("FAIL css_pause[%0d]: got SOMI=%b state=%0d want SOMI=0 state=1", p, SOMI, state_dbg);
                    end
                end
            end
            send_bit(k[i]);
        end
        @(negedge clk);
        SIMO = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_bits(input int n, output logic [255:0] v);
        v = '0;
        @(negedge clk);
        CSS  = 1'b0;
        mode = 1'b1;
        SIMO = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            v[k] = SOMI;
        end
    endtask

    task automatic test_reset();
        logic [255:0] v;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (SOMI !== 1'b0) begin
            bad++;
            $display("FAIL reset_somi: got %b want 0", SOMI);
        end
        total++;
        if (state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: got %0d want 0", state_dbg);
        end
        for (int i = 0; i < 50; i++) send_bit(C1_PT[i]);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (SOMI !== 1'b0 || state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL midload_reset: got SOMI=%b state=%0d want SOMI=0 state=0", SOMI, state_dbg);
        end
        reset = 1'b0;
        CSS   = 1'b1;
        @(negedge clk);
        total++;
        if (state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL after_reset_state: got %0d want 0", state_dbg);
        end
        load_block(FIPS_PT, FIPS_KEY, -1);
        read_bits(128, v);
        total++;
        if (v[127:0] !== FIPS_CT) begin
            bad++;
            $display("FAIL reset_reload_ct: got %h want %h", v[127:0], FIPS_CT);
        end
    endtask

    task automatic test_fips();
        logic [255:0] v;
        load_block(FIPS_PT, FIPS_KEY, -1);
        total++;
        if (state_dbg !== 2'd3) begin
            bad++;
            $display("FAIL fips_ready_state: got %0d want 3", state_dbg);
        end
        read_bits(128, v);
        total++;
        if (v[127:0] !== FIPS_CT) begin
            bad++;
            $display("FAIL fips_ct: got %h want %h", v[127:0], FIPS_CT);
        end
    endtask

    task automatic test_wrap();
        logic [255:0] v;
        load_block(FIPS_PT, FIPS_KEY, -1);
        read_bits(256, v);
        total++;
        if (v[127:0] !== FIPS_CT) begin
            bad++;
            $display("FAIL wrap_first: got %h want %h", v[127:0], FIPS_CT);
        end
        total++;
        if (v[255:128] !== FIPS_CT) begin
            bad++;
            $display("FAIL wrap_second: got %h want %h", v[255:128], FIPS_CT);
        end
    endtask

    task automatic test_css_pause();
        logic [255:0] v;
        load_block(C1_PT, C1_KEY, 64);
        read_bits(128, v);
        total++;
        if (v[127:0] !== C1_CT) begin
            bad++;
            $display("FAIL css_pause_ct: got %h want %h", v[127:0], C1_CT);
        end
    endtask

    task automatic test_early_read();
        logic [255:0] v;
        start_load();
        for (int i = 0; i < 100; i++) send_bit(FIPS_PT[i]);
        for (int p = 0; p < 6; p++) begin
            @(negedge clk);
            if (p > 0) begin
                total++;
                if (SOMI !== 1'b0 || state_dbg !== 2'd0) begin
                    bad++;
                    $display("FAIL early_read[%0d]: got SOMI=%b state=%0d want SOMI=0 state=0", p, SOMI, state_dbg);
                end
            end
            CSS  = 1'b0;
            mode = 1'b1;
            SIMO = 1'b1;
        end
        load_block(C1_PT, C1_KEY, -1);
        read_bits(128, v);
        total++;
        if (v[127:0] !== C1_CT) begin
            bad++;
            $display("FAIL early_read_ct: got %h want %h", v[127:0], C1_CT);
        end
    endtask

    task automatic test_extra_bits();
        logic [255:0] v;
        load_block(FIPS_PT, FIPS_KEY, -1);
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        @(negedge clk);
        total++;
        if (state_dbg !== 2'd3) begin
            bad++;
            $display("FAIL extra_bits_state: got %0d want 3", state_dbg);
        end
        read_bits(128, v);
        total++;
        if (v[127:0] !== FIPS_CT) begin
            bad++;
            $display("FAIL extra_bits_ct: got %h want %h", v[127:0], FIPS_CT);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] v;
        load_block(C1_PT, C1_KEY, -1);
        read_bits(128, v);
        total++;
        if (v[127:0] !== C1_CT) begin
            bad++;
            $display("FAIL b2b_first_ct: got %h want %h", v[127:0], C1_CT);
        end
        load_block(FIPS_PT, FIPS_KEY, -1);
        read_bits(128, v);
        total++;
        if (v[127:0] !== FIPS_CT) begin
            bad++;
            $display("FAIL b2b_second_ct: got %h want %h", v[127:0], FIPS_CT);
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_wrap();
        test_css_pause();
        test_early_read();
        test_extra_bits();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
